store_aligner: RTL

Store-side lane formatter and memory-write sequencer for the RV32IC load/store path: the write direction of the load sign/zero-extension path. It takes register data and size from execute (SB/SH/SW), narrows and shifts it into byte lanes with byte strobes, and drives word-aligned write beats to the data memory port. A misaligned store that crosses a word boundary is split into two beats.

---
 rtl/store_aligner.sv | 117 +++++++++++
 1 files changed

// File: rtl/store_aligner.sv
// Store lane formatter and word-aligned write sequencer; splits boundary-crossing stores.
// Optional feature macro: MISALIGNED_SPLIT_EN (undefined: boundary-crossing stores fault).
module store_aligner #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              done,
    output logic              fault
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  base_mask;
    logic [31:0] data_sel;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic        split;
    logic        reject;
    logic        accept;
    logic [31:0] hi_data;
    logic [3:0]  hi_strb;
    logic        split_q;
    logic        fault_q;

    always_comb begin
        base_mask = 4'b0000;
        data_sel  = '0;
        case (req_size)
            2'b00: begin
                base_mask = 4'b0001;
                data_sel  = {24'h000000, req_data[7:0]};
            end
            2'b01: begin
                base_mask = 4'b0011;
                data_sel  = {16'h0000, req_data[15:0]};
            end
            2'b10: begin
                base_mask = 4'b1111;
                data_sel  = req_data;
            end
            default: begin
                base_mask = 4'b0000;
                data_sel  = '0;
            end
        endcase
        mask8  = {4'b0000, base_mask} << req_addr[1:0];
        data64 = {32'h00000000, data_sel} << {req_addr[1:0], 3'b000};
        split  = |mask8[7:4];
`ifdef MISALIGNED_SPLIT_EN
        reject = (req_size == 2'b11);
`else
        reject = (req_size == 2'b11) || split;
`endif
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = reject ? RESP : BEAT0;
            BEAT0:   if (mem_ready) state_nxt = split_q ? BEAT1 : RESP;
            BEAT1:   if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are pure state decodes, so nothing on req_* or mem_ready reaches them.
    assign req_ready = (state == IDLE);
    assign mem_valid = (state == BEAT0) || (state == BEAT1);
    assign done      = (state == RESP);
    assign fault     = (state == RESP) && fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            hi_data   <= '0;
            hi_strb   <= '0;
            split_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else if (accept) begin
            fault_q   <= reject;
            split_q   <= split;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= data64[31:0];
            mem_wstrb <= mask8[3:0];
            hi_data   <= data64[63:32];
            hi_strb   <= mask8[7:4];
        end else if ((state == BEAT0) && mem_ready && split_q) begin
            // Address increment wraps naturally at the top of the address space.
            mem_addr  <= mem_addr + ADDR_W'(4);
            mem_wdata <= hi_data;
            mem_wstrb <= hi_strb;
        end
    end

endmodule
